keccak_chi_scheduler: RTL and testbench
=======================================

Name: keccak_chi_scheduler

Overview:
- Sequences the masked chi layer of one Keccak-f round over the 320 five-bit rows of the shared state.
- Each row is addressed as y*64+z. Rows are processed NUM_SBOX at a time through internal PINI/HPC3 chi S-box instances.
- Fresh randomness is drawn through a valid/ready handshake. Each result is written back to the state register file one cycle after issue.
- Sits between the round controller (start/done) and the shared-state register file and randomness source.

Parameters:
- security_order, 1, masking order; SH = security_order+1 shares.
- NUM_SBOX, 64, S-box instances in parallel; must divide 320. GROUPS = 320/NUM_SBOX; AW = max(1, clog2(GROUPS)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run chi over the full state.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse on the final write-back.
- rd_addr  out  AW  row-group read address; the register file returns data combinationally.
- rd_data  in  NUM_SBOX*5*SH  shared rows; S-box k uses bits [5*SH*k +: 5*SH], in the S-box share layout.
- rand_valid  in  1  randomness word available.
- rand_ready  out  1  randomness consumed this cycle if rand_valid.
- rand_data  in  NUM_SBOX*10*(SH*security_order/2)  fresh randomness, sliced per S-box k.
- wr_en  out  1  write-back strobe.
- wr_addr  out  AW  write-back row-group address.
- wr_data  out  NUM_SBOX*5*SH  chi output shares.
- stall_cnt  out  16  number of RUN cycles with rand_valid low, saturating, cleared on start.

Behaviour:
- States:
  - IDLE: start -> RUN, grp<=0, stall_cnt<=0.
  - RUN: issue = rand_valid. On issue, grp<=grp+1. Issue of grp==GROUPS-1 -> DRAIN.
  - DRAIN: one cycle -> IDLE.
- Combinational outputs:
  - rand_ready = (state==RUN). It must not depend on rand_valid.
  - rd_addr = grp.
  - rd_data and rand_data are sampled by the S-boxes only in issue cycles.
- Write-back path:
  - S-box latency is 1 cycle (HPC3 internal register).
  - wr_en is registered issue; wr_addr is registered grp at issue; wr_data is the S-box output.
  - Exactly GROUPS writes per run, addresses 0..GROUPS-1 in order, no duplicates.
- Stalls:
  - rand_valid low in RUN: no issue, grp held, stall_cnt increments.
  - The in-flight group still writes back on the following cycle.
- busy = (state!=IDLE). done = 1 in the DRAIN cycle, coincident with the last wr_en.
- Timing with rand_valid always high: start sampled at edge 0; issues in cycles 1..GROUPS; done in cycle GROUPS+1; run length GROUPS+1 cycles.
- Start rules:
  - start while busy is ignored.
  - start in the DRAIN cycle is ignored; the next run needs start in IDLE.
- Reset:
  - Reset values: busy=0, done=0, wr_en=0, wr_addr=0, rd_addr=0, rand_ready=0, stall_cnt=0, state=IDLE.
  - Reset mid-run aborts immediately; no wr_en is produced after rst_n falls.
  - S-box datapath registers carry no reset; wr_en gating makes this safe.
- Security:
  - Each randomness word is used for exactly one issue and never reused.
  - No share recombination in the controller.
  - Unmasked output equals chi(row): out[i] = a[i] ^ (~a[i+1] & a[i+2]), indices mod 5.

Decomposition:
- Shared package keccak_mask_pkg holds:
  - SH(order) and RAND_PER_SBOX(order) = 10*SH*order/2;
  - ROWS=320;
  - the state encoding (IDLE, RUN, DRAIN).
- Sub-module: keccak_sbox_pini (existing), instantiated NUM_SBOX times via generate.

Test Plan:
- All-zero state, rand_valid=1, order 1, NUM_SBOX=64 -> 5 writes at addresses 0..4 in cycles 2..6, done in cycle 6, unmasked output all zero, stall_cnt=0.
- Every row unmasked 0x01 (random sharing) -> every written row unmasks to 0x09; row 0x1F -> 0x1F.
- rand_valid low for 3 cycles after the 2nd issue -> one extra write of group 1 then a pause; done in cycle 9; stall_cnt=3; wr_addr sequence still 0..4.
- start pulsed in cycles 3 and 6 of a run -> ignored; exactly 5 writes; busy falls after cycle 6.
- rst_n low in cycle 3 -> wr_en=0 and busy=0 from that point; a new start afterwards completes a full 5-group run.
- Same state run twice with different rand_data -> identical unmasked outputs, differing share values; NUM_SBOX=5 regression gives 64 writes, done in cycle 65.

Source files
------------

// File: rtl/keccak_mask_pkg.sv
// Shared definitions for the masked Keccak chi datapath: share counts,
// randomness sizing, row count and the chi scheduler state encoding.
package keccak_mask_pkg;

    localparam int ROWS = 320;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } chi_state_e;

    function automatic int num_shares(input int order);
        return order + 1;
    endfunction

    // Two fresh bits per share pair for each of the five AND gates of one row.
    function automatic int rand_per_sbox(input int order);
        return 10 * num_shares(order) * order / 2;
    endfunction

    // Dense index of the unordered share pair (i, j), i < j.
    function automatic int pair_index(input int i, input int j, input int sh);
        return i * sh - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/keccak_sbox_pini.sv
// One masked 5-bit chi row built from HPC3 multiplications; the cross-domain
// terms are registered before compression, giving one cycle of latency.
module keccak_sbox_pini
    import keccak_mask_pkg::*;
#(
    parameter  int ORDER = 1,
    localparam int SH    = num_shares(ORDER),
    localparam int RW    = rand_per_sbox(ORDER),
    localparam int NP    = SH * ORDER / 2
) (
    input  logic            clk,
    input  logic            en,
    input  logic [5*SH-1:0] din,
    input  logic [RW-1:0]   rnd,
    output logic [5*SH-1:0] dout
);

    logic [4:0] lin   [SH];
    logic [4:0] x     [SH];
    logic [4:0] y     [SH];
    logic [4:0] r     [SH][SH];
    logic [4:0] rp    [SH][SH];
    logic [4:0] lin_q [SH];
    logic [4:0] u_q   [SH][SH];
    logic [4:0] v_q   [SH][SH];

    // x = ~a[i+1] (complement on share 0 only), y = a[i+2]; r/rp symmetric per pair.
    always_comb begin
        for (int s = 0; s < SH; s++) begin
            lin[s] = din[5*s +: 5];
            x[s]   = {lin[s][0], lin[s][4:1]};
            y[s]   = {lin[s][1:0], lin[s][4:2]};
        end
        x[0] = ~x[0];
        for (int i = 0; i < SH; i++) begin
            for (int j = 0; j < SH; j++) begin
                r[i][j]  = '0;
                rp[i][j] = '0;
                if (i != j) begin
                    for (int b = 0; b < 5; b++) begin
                        int idx;
                        idx = 2 * (b * NP + pair_index((i < j) ? i : j, (i < j) ? j : i, SH));
                        r[i][j][b]  = rnd[idx];
                        rp[i][j][b] = rnd[idx + 1];
                    end
                end
            end
        end
    end

    // NOTE: datapath flops carry no reset; the scheduler's wr_en qualifies their contents.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < SH; i++) begin
                lin_q[i] <= lin[i];
                for (int j = 0; j < SH; j++) begin
                    u_q[i][j] <= (i == j) ? (x[i] & y[i]) : (x[i] & (y[j] ^ r[i][j]));
                    v_q[i][j] <= (~x[i] & r[i][j]) ^ rp[i][j];
                end
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        dout = '0;
        for (int i = 0; i < SH; i++) begin
            logic [4:0] acc;
            acc = lin_q[i];
            for (int j = 0; j < SH; j++) begin
                acc = acc ^ u_q[i][j] ^ v_q[i][j];
            end
            dout[5*i +: 5] = acc;
        end
    end

endmodule

// File: rtl/keccak_chi_scheduler.sv
// Walks the 320 shared rows through NUM_SBOX masked chi S-boxes, one row group
// per accepted randomness word, writing each result back one cycle later.
module keccak_chi_scheduler
    import keccak_mask_pkg::*;
#(
    parameter  int security_order = 1,
    parameter  int NUM_SBOX       = 64,
    localparam int SH             = num_shares(security_order),
    localparam int RPS            = rand_per_sbox(security_order),
    localparam int GROUPS         = ROWS / NUM_SBOX,
    localparam int AW             = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [AW-1:0]             rd_addr,
    input  logic [NUM_SBOX*5*SH-1:0]  rd_data,
    input  logic                      rand_valid,
    output logic                      rand_ready,
    input  logic [NUM_SBOX*RPS-1:0]   rand_data,
    output logic                      wr_en,
    output logic [AW-1:0]             wr_addr,
    output logic [NUM_SBOX*5*SH-1:0]  wr_data,
    output logic [15:0]               stall_cnt
);

    chi_state_e    state;
    logic [AW-1:0] grp;
    logic          issue;
    logic          last;

    assign issue      = (state == RUN) && rand_valid;
    assign last       = (grp == AW'(GROUPS - 1));
    assign busy       = (state != IDLE);
    assign rand_ready = (state == RUN);
    assign rd_addr    = grp;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grp       <= '0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            stall_cnt <= '0;
        end else begin
            wr_en <= issue;
            done  <= issue && last;
            if (issue) begin
                wr_addr <= grp;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        grp       <= '0;
                        stall_cnt <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        grp <= last ? '0 : grp + AW'(1);
                        if (last) begin
                            state <= DRAIN;
                        end
                    end else if (stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
        keccak_sbox_pini #(
            .ORDER (security_order)
        ) u_sbox (
            .clk  (clk),
            .en   (issue),
            .din  (rd_data[5*SH*k +: 5*SH]),
            .rnd  (rand_data[RPS*k +: RPS]),
            .dout (wr_data[5*SH*k +: 5*SH])
        );
    end

endmodule

// File: tb/tb_keccak_chi_scheduler.sv
// Randomized directed bench for keccak_chi_scheduler: a 64-S-box instance for the
// main scenarios and a 5-S-box instance for the long-run regression.
module tb_keccak_chi_scheduler;

    localparam int NA = 64;
    localparam int NB = 5;
    localparam int GA = 320 / NA;
    localparam int GB = 320 / NB;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         start      = 1'b0;
    logic         rand_valid = 1'b0;
    logic [639:0] rand_data  = '0;
    logic         sel_b      = 1'b0;
    logic [9:0]   mem [320];

    logic         a_busy, a_done, a_rand_ready, a_wr_en;
    logic [2:0]   a_rd_addr, a_wr_addr;
    logic [639:0] a_rd_data, a_wr_data;
    logic [15:0]  a_stall_cnt;
    logic         b_busy, b_done, b_rand_ready, b_wr_en;
    logic [5:0]   b_rd_addr, b_wr_addr;
    logic [49:0]  b_rd_data, b_wr_data;
    logic [15:0]  b_stall_cnt;

    wire          a_start     = start && !sel_b;
    wire          b_start     = start && sel_b;
    wire          o_busy      = sel_b ? b_busy : a_busy;
    wire          o_done      = sel_b ? b_done : a_done;
    wire          o_ready     = sel_b ? b_rand_ready : a_rand_ready;
    wire          o_wr_en     = sel_b ? b_wr_en : a_wr_en;
    wire [5:0]    o_rd_addr   = sel_b ? b_rd_addr : {3'b000, a_rd_addr};
    wire [5:0]    o_wr_addr   = sel_b ? b_wr_addr : {3'b000, a_wr_addr};
    wire [639:0]  o_wr_data   = sel_b ? {590'd0, b_wr_data} : a_wr_data;
    wire [15:0]   o_stall_cnt = sel_b ? b_stall_cnt : a_stall_cnt;

    keccak_chi_scheduler #(.security_order(1), .NUM_SBOX(NA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rand_valid(rand_valid),
        .rand_ready(a_rand_ready), .rand_data(rand_data), .wr_en(a_wr_en),
        .wr_addr(a_wr_addr), .wr_data(a_wr_data), .stall_cnt(a_stall_cnt)
    );

    keccak_chi_scheduler #(.security_order(1), .NUM_SBOX(NB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rand_valid(rand_valid),
        .rand_ready(b_rand_ready), .rand_data(rand_data[49:0]), .wr_en(b_wr_en),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data), .stall_cnt(b_stall_cnt)
    );

    always #5 clk = ~clk;

    // Combinational register file: share 0 in bits [4:0], share 1 in bits [9:5].
    always_comb begin
        a_rd_data = '0;
        for (int k = 0; k < NA; k++) begin
            if (int'(a_rd_addr) * NA + k < 320) a_rd_data[10*k +: 10] = mem[int'(a_rd_addr) * NA + k];
        end
        b_rd_data = '0;
        for (int k = 0; k < NB; k++) begin
            b_rd_data[10*k +: 10] = mem[int'(b_rd_addr) * NB + k];
        end
    end

    int checks   = 0;
    int failures = 0;
    logic [639:0] g0_shares;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] chi5(input logic [4:0] a);
        logic [4:0] o;
        for (int i = 0; i < 5; i++) o[i] = a[i] ^ (~a[(i + 1) % 5] & a[(i + 2) % 5]);
        return o;
    endfunction

    function automatic logic [319:0] exp_group(input int g, input int n);
        logic [319:0] v = '0;
        for (int k = 0; k < n; k++) v[5*k +: 5] = chi5(mem[g * n + k][4:0] ^ mem[g * n + k][9:5]);
        return v;
    endfunction

    function automatic logic [319:0] unmask_group(input logic [639:0] d, input int n);
        logic [319:0] v = '0;
        for (int k = 0; k < n; k++) v[5*k +: 5] = d[10*k +: 5] ^ d[10*k + 5 +: 5];
        return v;
    endfunction

    // mode < 0: random rows; otherwise every row holds that value. Sharing is always random.
    task automatic fill(input int mode);
        for (int r = 0; r < 320; r++) begin
            logic [4:0] val, s0;
            val    = (mode < 0) ? 5'($urandom) : 5'(mode);
            s0     = 5'($urandom);
            mem[r] = {s0 ^ val, s0};
        end
    endtask

    task automatic new_rand();
        for (int i = 0; i < 20; i++) rand_data[32*i +: 32] = $urandom;
    endtask

    // One run: start at edge 0, optional stall after the 2nd issue, spurious starts,
    // optional reset in cycle rst_cyc. Expected schedule comes from the issue count.
    task automatic run_chi(input string tag, input int stall_len, input int spur0,
                           input int spur1, input int rst_cyc, input int exp_done);
        int  groups     = sel_b ? GB : GA;
        int  n          = sel_b ? NB : NA;
        int  issued     = 0;
        int  stall_left = stall_len;
        int  stalls     = 0;
        int  writes     = 0;
        int  done_cyc   = -1;
        int  pend_addr  = 0;
        bit  pend_wr    = 0;
        bit  aborted    = 0;
        bit  in_run, drain, valid;
        start      = 1'b1;
        rand_valid = 1'b1;
        new_rand();
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= groups + stall_len + 3; c++) begin
            in_run = (issued < groups);
            drain  = pend_wr && (pend_addr == groups - 1);
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check({tag, " abort wr_en"}, int'(o_wr_en), 0);
                check({tag, " abort busy"}, int'(o_busy), 0);
                check({tag, " abort rand_ready"}, int'(o_ready), 0);
                aborted = 1;
                break;
            end
            check({tag, " wr_en"}, int'(o_wr_en), int'(pend_wr));
            check({tag, " busy"}, int'(o_busy), int'(in_run || drain));
            check({tag, " done"}, int'(o_done), int'(drain));
            check({tag, " rand_ready"}, int'(o_ready), int'(in_run));
            if (in_run) check({tag, " rd_addr"}, int'(o_rd_addr), issued);
            if (o_wr_en) begin
                writes++;
                check({tag, " wr_addr"}, int'(o_wr_addr), pend_addr);
                check_data({tag, " chi data"}, unmask_group(o_wr_data, n), exp_group(pend_addr, n));
                if (pend_addr == 0) g0_shares = o_wr_data;
            end
            if (o_done) done_cyc = c;
            start = (c == spur0 || c == spur1);
            valid = 1'b1;
            if (in_run && issued == 2 && stall_left > 0) begin
                valid = 1'b0;
                stall_left--;
                stalls++;
            end
            rand_valid = valid;
            new_rand();
            pend_wr   = in_run && valid;
            pend_addr = issued;
            if (pend_wr) issued++;
            @(negedge clk);
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check({tag, " held wr_en"}, int'(o_wr_en), 0);
            check({tag, " held busy"}, int'(o_busy), 0);
            rst_n = 1'b1;
            @(negedge clk);
        end else begin
            check({tag, " write count"}, writes, groups);
            check({tag, " done cycle"}, done_cyc, exp_done);
            check({tag, " stall_cnt"}, int'(o_stall_cnt), stalls);
            check({tag, " stall_cnt value"}, int'(o_stall_cnt), stall_len);
        end
    endtask

    initial begin
        logic [639:0] first_shares;
        fill(0);
        repeat (3) @(negedge clk);
        check("reset busy", int'(a_busy), 0);
        check("reset done", int'(a_done), 0);
        check("reset wr_en", int'(a_wr_en), 0);
        check("reset wr_addr", int'(a_wr_addr), 0);
        check("reset rd_addr", int'(a_rd_addr), 0);
        check("reset rand_ready", int'(a_rand_ready), 0);
        check("reset stall_cnt", int'(a_stall_cnt), 0);
        check("reset b busy", int'(b_busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill(0);    run_chi("zero", 0, 0, 0, 0, 6);
        fill(1);    run_chi("row01", 0, 0, 0, 0, 6);
        fill(31);   run_chi("row1f", 0, 0, 0, 0, 6);
        fill(-1);   run_chi("stall", 3, 0, 0, 0, 9);
        fill(-1);   run_chi("spurious", 0, 3, 6, 0, 6);
        fill(-1);   run_chi("abort", 0, 0, 0, 3, 0);
        run_chi("after_abort", 0, 0, 0, 0, 6);

        fill(-1);
        run_chi("twice_a", 0, 0, 0, 0, 6);
        first_shares = g0_shares;
        run_chi("twice_b", 0, 0, 0, 0, 6);
        check("twice shares differ", int'(first_shares !== g0_shares), 1);

        sel_b = 1'b1;
        fill(-1);   run_chi("nsbox5", 0, 0, 0, 0, 65);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
